// File: rtl/rcs_div_ctrl.sv
// Sequential restoring divider: one quotient bit per clock through a shared
// (WIDTH+1)-bit ripple-carry subtractor, with a start/busy/done handshake.
module rcs_div_ctrl #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StIter, StDone} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  d_q, d_d;
    logic [WIDTH-1:0]  r_q, r_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              dz_q, dz_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [WIDTH-1:0]  quo_q, quo_d;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic              dzo_q, dzo_d;

    logic [WIDTH:0]    p;
    logic [WIDTH:0]    b_inv;
    logic [WIDTH+1:0]  c;
    logic [WIDTH-1:0]  diff;
    logic              carry;

    // Ripple-carry subtract P - {0,D}: P + ~{0,D} + 1; carry-out 1 means no borrow.
    always_comb begin
        p     = {r_q, a_q[WIDTH-1]};
        b_inv = ~{1'b0, d_q};
        c     = '0;
        diff  = '0;
        c[0]  = 1'b1;
        for (int unsigned i = 0; i <= WIDTH; i++) begin
            if (i < WIDTH) begin
                diff[i] = p[i] ^ b_inv[i] ^ c[i];
            end
            c[i+1] = (p[i] & b_inv[i]) | (c[i] & (p[i] ^ b_inv[i]));
        end
        carry = c[WIDTH+1];
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        d_d     = d_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        dz_d    = dz_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dzo_d   = dzo_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = dividend;
                    d_d     = divisor;
                    r_d     = '0;
                    cnt_d   = '0;
                    dz_d    = (divisor == '0);
                    busy_d  = 1'b1;
                    state_d = StIter;
                end
            end
            StIter: begin
                r_d   = carry ? diff : p[WIDTH-1:0];
                a_d   = {a_q[WIDTH-2:0], carry};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    quo_d   = a_d;
                    rem_d   = r_d;
                    dzo_d   = dz_q;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dzo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            d_q     <= d_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            dz_q    <= dz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dzo_q   <= dzo_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dzo_q;

endmodule

// File: tb/tb_rcs_div_ctrl.sv
// Directed bench for rcs_div_ctrl at WIDTH=4; inputs change and outputs are
// sampled 1ns after each rising edge.
module tb_rcs_div_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] dividend = '0;
    logic [3:0] divisor = '0;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int checks = 0;
    int failures = 0;

    rcs_div_ctrl #(.WIDTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Issue one start pulse and wait (bounded) for done; lat counts edges after accept.
    task automatic do_op(input logic [3:0] a, input logic [3:0] b,
                         output int lat, output int bcnt);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 0;
        bcnt  = 0;
        while (done !== 1'b1 && lat < 20) begin
            if (busy === 1'b1) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 11'd0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%b done=%b q=%0d r=%0d dz=%b, want all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        int lat, bcnt;
        do_op(4'd13, 4'd3, lat, bcnt);
        checks++;
        if (lat !== 4) begin
            failures++;
            $display("FAIL basic_latency: got %0d, want 4", lat);
        end
        checks++;
        if (bcnt !== 4) begin
            failures++;
            $display("FAIL basic_busy_cycles: got %0d, want 4", bcnt);
        end
        checks++;
        if (quotient !== 4'd4 || remainder !== 4'd1 || div_by_zero !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_13_3: got q=%0d r=%0d dz=%b busy=%b, want q=4 r=1 dz=0 busy=0",
                     quotient, remainder, div_by_zero, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || quotient !== 4'd4 || remainder !== 4'd1) begin
            failures++;
            $display("FAIL basic_done_pulse: got done=%b q=%0d r=%0d, want done=0 q=4 r=1",
                     done, quotient, remainder);
        end
    endtask

    task automatic test_corners();
        logic [3:0] ta [4] = '{4'd15, 4'd2, 4'd0, 4'd15};
        logic [3:0] tb [4] = '{4'd1,  4'd9, 4'd5, 4'd15};
        logic [3:0] tq [4] = '{4'd15, 4'd0, 4'd0, 4'd1};
        logic [3:0] tr [4] = '{4'd0,  4'd2, 4'd0, 4'd0};
        int lat, bcnt;
        for (int i = 0; i < 4; i++) begin
            do_op(ta[i], tb[i], lat, bcnt);
            checks++;
            if (lat !== 4 || quotient !== tq[i] || remainder !== tr[i] || div_by_zero !== 1'b0) begin
                failures++;
                $display("FAIL corner_%0d_%0d: got lat=%0d q=%0d r=%0d dz=%b, want lat=4 q=%0d r=%0d dz=0",
                         ta[i], tb[i], lat, quotient, remainder, div_by_zero, tq[i], tr[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_div_zero();
        int lat, bcnt;
        do_op(4'd7, 4'd0, lat, bcnt);
        checks++;
        if (lat !== 4 || quotient !== 4'd15 || remainder !== 4'd7 || div_by_zero !== 1'b1) begin
            failures++;
            $display("FAIL div_zero_7_0: got lat=%0d q=%0d r=%0d dz=%b, want lat=4 q=15 r=7 dz=1",
                     lat, quotient, remainder, div_by_zero);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (div_by_zero !== 1'b1) begin
            failures++;
            $display("FAIL div_zero_hold: got dz=%b, want 1", div_by_zero);
        end
        do_op(4'd9, 4'd2, lat, bcnt);
        checks++;
        if (quotient !== 4'd4 || remainder !== 4'd1 || div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL after_zero_9_2: got q=%0d r=%0d dz=%b, want q=4 r=1 dz=0",
                     quotient, remainder, div_by_zero);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ignore_start();
        int ndone = 0;
        int done_at = -1;
        logic [3:0] q_seen = '0;
        logic [3:0] r_seen = '0;
        dividend = 4'd12;
        divisor  = 4'd5;
        start    = 1'b1;
        @(posedge clk); #1;
        // Hold start high with new operands through ITER and DONE.
        dividend = 4'd3;
        divisor  = 4'd1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (c == 5) start = 1'b0;
            if (done === 1'b1) begin
                ndone++;
                if (done_at < 0) begin
                    done_at = c;
                    q_seen  = quotient;
                    r_seen  = remainder;
                end
            end
        end
        checks++;
        if (ndone !== 1 || done_at !== 4) begin
            failures++;
            $display("FAIL ignore_start_pulses: got %0d done pulses first at %0d, want 1 at 4",
                     ndone, done_at);
        end
        checks++;
        if (q_seen !== 4'd2 || r_seen !== 4'd2) begin
            failures++;
            $display("FAIL ignore_start_12_5: got q=%0d r=%0d, want q=2 r=2", q_seen, r_seen);
        end
    endtask

    task automatic test_async_reset();
        int lat, bcnt;
        dividend = 4'd14;
        divisor  = 4'd3;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 11'd0) begin
            failures++;
            $display("FAIL async_reset_clear: got busy=%b done=%b q=%0d r=%0d dz=%b, want all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_hold: got busy=%b done=%b, want 0 0", busy, done);
        end
        #2;
        rst = 1'b0;
        @(posedge clk); #1;
        do_op(4'd14, 4'd3, lat, bcnt);
        checks++;
        if (lat !== 4 || quotient !== 4'd4 || remainder !== 4'd2 || div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL after_reset_14_3: got lat=%0d q=%0d r=%0d dz=%b, want lat=4 q=4 r=2 dz=0",
                     lat, quotient, remainder, div_by_zero);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [3:0] a, b, eq, er;
        logic       edz;
        int cyc;
        start = 1'b1;
        for (int i = 0; i < 256; i++) begin
            a = 4'(i >> 4);
            b = 4'(i & 15);
            dividend = a;
            divisor  = b;
            eq  = (b != 0) ? 4'(a / b) : 4'd15;
            er  = (b != 0) ? 4'(a % b) : a;
            edz = (b == 0);
            cyc = 0;
            do begin
                @(posedge clk); #1;
                cyc++;
            end while (done !== 1'b1 && cyc < 20);
            checks++;
            if (quotient !== eq || remainder !== er || div_by_zero !== edz ||
                (i > 0 && cyc !== 6) || (i == 0 && cyc !== 5)) begin
                failures++;
                $display("FAIL b2b_%0d_%0d: got q=%0d r=%0d dz=%b gap=%0d, want q=%0d r=%0d dz=%b gap=%0d",
                         a, b, quotient, remainder, div_by_zero, cyc, eq, er, edz,
                         (i == 0) ? 5 : 6);
            end
        end
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_div_zero();
        test_ignore_start();
        test_async_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rcs_div_ctrl.md
Name: rcs_div_ctrl

Overview:
- Sequential restoring divider controller. It drives one shared (WIDTH+1)-bit ripple-carry subtractor (a ^ ~b with carry-in 1) through WIDTH iterations, one quotient bit per clock.
- Provides a start/busy/done handshake for unsigned division in the arithmetic-logic library.
- The subtractor's carry-out (1 = no borrow) is the only compare decision.

Parameters:
- WIDTH, 4, operand/quotient/remainder bit width (>= 2).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- dividend  input  WIDTH  unsigned dividend; captured on the accepting edge.
- divisor  input  WIDTH  unsigned divisor; captured on the accepting edge.
- busy  output  1  high while in ITER.
- done  output  1  one-cycle pulse; results valid.
- quotient  output  WIDTH  unsigned quotient, registered.
- remainder  output  WIDTH  unsigned remainder, registered.
- div_by_zero  output  1  set with done when the captured divisor == 0.

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; all internal registers 0.
- States: IDLE, ITER, DONE. State register, counter, and all outputs are registered.
- Internal registers:
  - A: WIDTH, dividend shift.
  - D: WIDTH, divisor.
  - R: WIDTH, partial remainder.
  - cnt: clog2(WIDTH+1) bits.
- IDLE:
  - start=1 at edge E0 -> A=dividend, D=divisor, R=0, cnt=0, dz=(divisor==0), state=ITER, busy=1.
  - quotient/remainder/div_by_zero keep their previous values until done.
  - start=0 -> stay in IDLE.
- ITER (edges E1..EWIDTH), each edge:
  - P = {R, A[WIDTH-1]} (WIDTH+1 bits).
  - Subtractor computes P + ~{1'b0,D} + 1 -> diff, carry.
  - carry=1: R = diff[WIDTH-1:0]. carry=0: R = P[WIDTH-1:0].
  - A = {A[WIDTH-2:0], carry}; cnt++.
  - On the edge where cnt reaches WIDTH-1 (the WIDTH-th iteration):
    - quotient = next A; remainder = next R; div_by_zero = dz.
    - state=DONE, busy=0, done=1.
- DONE:
  - Lasts exactly one cycle, then state=IDLE, done=0.
  - start is ignored here. The earliest re-accept is the first IDLE cycle after done drops.
- Latency:
  - done is high in the cycle following edge EWIDTH, i.e. WIDTH clocks after the accepting edge.
  - The latency is fixed and independent of operand values, including divisor=0.
  - Back-to-back throughput: one result per WIDTH+2 cycles.
- start while busy or in DONE: ignored. No queuing; the in-flight operation is unaffected.
- Operand inputs may change freely after the accepting edge; only the captured copies are used.
- Divisor = 0:
  - No special datapath; the algorithm runs normally and naturally yields quotient = all ones, remainder = dividend.
  - div_by_zero=1 with done. It holds until the next done, which writes the new value.
- Arithmetic:
  - P is WIDTH+1 bits, so a shifted remainder >= 2^WIDTH never overflows.
  - carry is the subtractor's MSB carry-out; no separate comparator is permitted.
- Invariant at done, divisor != 0: dividend == quotient*divisor + remainder and remainder < divisor.
- Reset mid-operation: aborts immediately, outputs return to reset values, no done pulse. The first start after reset release behaves normally.
- Outputs hold their last result in IDLE indefinitely.

Test Plan:
- WIDTH=4, reset then start with 13/3 -> busy=1 for 4 cycles; done pulses 4 clocks after accept; quotient=4, remainder=1, div_by_zero=0.
- Corner operands, each with the same 4-clock latency:
  - 15/1 -> q=15, r=0.
  - 2/9 -> q=0, r=2.
  - 0/5 -> q=0, r=0.
  - 15/15 -> q=1, r=0.
- 7/0 -> done after 4 clocks; q=15, r=7, div_by_zero=1. Next op 9/2 -> q=4, r=1, div_by_zero=0.
- Start 12/5 accepted; pulse start with 3/1 during ITER and DONE, and change the dividend/divisor inputs mid-op -> single done with q=2, r=2; no second done.
- Assert rst asynchronously (between edges) at iteration 2 of 14/3 -> busy, done, q, r all 0 immediately. After release, 14/3 -> q=4, r=2.
- Exhaustive: all 256 dividend/divisor pairs back-to-back, start held high -> one result every 6 cycles. Invariant holds for divisor != 0; divisor=0 cases give q=15, r=dividend.
